// File: rtl/vdp_vram_host_write_port_if.sv
// Host-write / arbiter-slot bundle for vdp_vram_host_write_port.
// slave = the write port itself, master = the host/arbiter side driving it.
interface vdp_vram_host_write_port_if;
    logic        host_address_write;
    logic        host_increment_write;
    logic        host_data_write;
    logic [15:0] host_data;
    logic        host_ready;
    logic        host_idle;
    logic        host_overflow;
    logic        vram_written;
    logic        vram_write_inhibit;
    logic [1:0]  vram_port_write_en_mask;
    logic [13:0] vram_write_address_16b;
    logic [15:0] vram_write_data_16b;

    modport slave (
        input  host_address_write,
        input  host_increment_write,
        input  host_data_write,
        input  host_data,
        output host_ready,
        output host_idle,
        output host_overflow,
        input  vram_written,
        input  vram_write_inhibit,
        output vram_port_write_en_mask,
        output vram_write_address_16b,
        output vram_write_data_16b
    );

    modport master (
        output host_address_write,
        output host_increment_write,
        output host_data_write,
        output host_data,
        input  host_ready,
        input  host_idle,
        input  host_overflow,
        output vram_written,
        output vram_write_inhibit,
        input  vram_port_write_en_mask,
        input  vram_write_address_16b,
        input  vram_write_data_16b
    );
endinterface

// File: rtl/vdp_vram_host_write_port.sv
// Host VRAM write queue with auto-incrementing word pointer, retired by arbiter host slots.
// Define VDP_HOST_WRITE_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module vdp_vram_host_write_port #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input logic                          clk,
    input logic                          reset_n,
    vdp_vram_host_write_port_if.slave    bus
);

`ifdef VDP_HOST_WRITE_FIFO_EN
    localparam int unsigned Depth = FIFO_DEPTH;
`else
    localparam int unsigned Depth = 1;
`endif
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 2..32");
    end

    // Entry layout: {word pointer[14:0], data[15:0]}
    logic [30:0]     r_mem [Depth];
    logic [14:0]     r_ptr;
    logic [7:0]      r_inc;
    logic [IdxW-1:0] r_rd;
    logic [IdxW-1:0] r_wr;
    logic [CntW-1:0] r_count;
    logic            r_overflow;
    logic [1:0]      r_mask;
    logic [13:0]     r_addr;
    logic [15:0]     r_data;

    logic            w_full;
    logic            w_empty;
    logic            w_data_req;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [30:0]     w_entry;
    logic [IdxW-1:0] w_rd_next;
    logic [IdxW-1:0] w_wr_next;
    logic [IdxW-1:0] w_rd_d;
    logic [CntW-1:0] w_count_d;
    logic [CntW-1:0] w_count_after_pop;
    logic [30:0]     w_head;
    logic            w_head_valid;

    assign w_full     = (r_count == CntW'(Depth));
    assign w_empty    = (r_count == '0);
    // Address and increment strobes take priority and swallow a same-cycle data strobe.
    assign w_data_req = bus.host_data_write && !bus.host_address_write &&
                        !bus.host_increment_write;
    assign w_pop      = bus.vram_written && !bus.vram_write_inhibit && !w_empty;
    assign w_push     = w_data_req && (!w_full || w_pop);
    assign w_drop     = w_data_req && w_full && !w_pop;
    assign w_entry    = {r_ptr, bus.host_data};

    assign w_rd_next  = (r_rd == IdxW'(Depth - 1)) ? '0 : r_rd + IdxW'(1);
    assign w_wr_next  = (r_wr == IdxW'(Depth - 1)) ? '0 : r_wr + IdxW'(1);
    assign w_rd_d     = w_pop ? w_rd_next : r_rd;

    assign w_count_after_pop = r_count - CntW'(w_pop);

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CntW'(1);
        end
    end

    // Next head: a surviving stored entry, else the entry being pushed this cycle.
    always_comb begin
        w_head_valid = (w_count_after_pop != '0) || w_push;
        w_head       = (w_count_after_pop != '0) ? r_mem[w_rd_d] : w_entry;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_inc      <= 8'd1;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_mask     <= 2'b00;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (bus.host_address_write) begin
                r_ptr <= bus.host_data[14:0];
            end else if (bus.host_increment_write) begin
                r_inc <= bus.host_data[7:0];
            end else if (w_push) begin
                r_ptr <= r_ptr + 15'(r_inc);
            end
            if (w_push) begin
                r_wr <= w_wr_next;
            end
            r_rd       <= w_rd_d;
            r_count    <= w_count_d;
            r_overflow <= w_drop;
            // Address/data keep their last values when the queue runs dry.
            if (w_head_valid) begin
                r_mask <= w_head[16] ? 2'b10 : 2'b01;
                r_addr <= w_head[30:17];
                r_data <= w_head[15:0];
            end else begin
                r_mask <= 2'b00;
            end
        end
    end

    assign bus.host_ready              = !w_full;
    assign bus.host_idle               = w_empty;
    assign bus.host_overflow           = r_overflow;
    assign bus.vram_port_write_en_mask = r_mask;
    assign bus.vram_write_address_16b  = r_addr;
    assign bus.vram_write_data_16b     = r_data;

endmodule
